ir_queue: RTL and testbench

//  Parametrised instruction queue; successor to the single-entry instruction register.

---
 rtl/ir_queue.sv | 75 +++++++
 tb/tb_ir_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// Instruction queue between the RAM fetch path and the decoder: DEPTH entries of
// {instr, pc}, valid/ready on both sides, synchronous flush for branches/jumps.
module ir_queue #(
    parameter int IW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IW-1:0]            in_instr,
    input  logic [AW-1:0]            in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IW-1:0]            out_instr,
    output logic [AW-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    // Handshake flags depend only on registered occupancy, so in_ready has no
    // combinational path from out_ready and reset clears both outputs instantly.
    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = cnt;

    assign head      = mem[rd_ptr];
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc    = out_valid ? head.pc    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
    end

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: a queue-based reference model tracks accepted
// entries; a negedge monitor compares every DUT output against it.
module tb_ir_queue;

    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic [AW-1:0] in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [CW-1:0] count;

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } ent_t;

    ent_t model_q[$];
    int   checks   = 0;
    int   failures = 0;

    ir_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted word joins the back, a taken word leaves the front.
    always @(posedge clk) begin
        bit do_push, do_pop;
        if (!rst_n || flush) begin
            model_q.delete();
        end else begin
            do_pop  = out_ready && model_q.size() > 0;
            do_push = in_valid && model_q.size() < DEPTH;
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back('{instr: in_instr, pc: in_pc});
        end
    end

    always @(negedge rst_n) model_q.delete();

    // Monitor: every output is compared against the model once per cycle.
    always @(negedge clk) begin
        int sz;
        sz = model_q.size();
        chk("mon_count",     64'(count),     64'(sz));
        chk("mon_out_valid", 64'(out_valid), 64'(sz != 0));
        chk("mon_in_ready",  64'(in_ready),  64'(sz != DEPTH));
        chk("mon_out_instr", 64'(out_instr), sz != 0 ? 64'(model_q[0].instr) : 64'd0);
        chk("mon_out_pc",    64'(out_pc),    sz != 0 ? 64'(model_q[0].pc)    : 64'd0);
    end

    task automatic cyc(input logic v, input logic [IW-1:0] ins, input logic [AW-1:0] pc,
                       input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFFF_FFFF;
        in_pc     = 32'h40;
        out_ready = 1'b0;
        #1;
        // Reset with in_valid held high: nothing gets in.
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready",  64'(in_ready),  64'd1);
            chk("rst_count",     64'(count),     64'd0);
            chk("rst_out_instr", 64'(out_instr), 64'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // First pushes; head visible one edge after its push.
        cyc(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
        chk("head_valid", 64'(out_valid), 64'd1);
        chk("head_instr", 64'(out_instr), 64'h13);
        chk("head_pc",    64'(out_pc),    64'h0);
        cyc(1'b1, 32'h0010_0093, 32'h4, 1'b0, 1'b0);
        chk("count_two",  64'(count), 64'd2);

        // Fill, then offer a fifth word that must be refused.
        cyc(1'b1, 32'hA000_0001, 32'h8, 1'b0, 1'b0);
        cyc(1'b1, 32'hA000_0002, 32'hC, 1'b0, 1'b0);
        chk("full_count",    64'(count),    64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, 32'hBAD0_0005, 32'h10, 1'b0, 1'b0);
        chk("full_5th_count", 64'(count), 64'd4);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("pop_count",    64'(count),     64'd3);
        chk("pop_in_ready", 64'(in_ready),  64'd1);
        chk("pop_head",     64'(out_instr), 64'h0010_0093);

        // Streaming push+pop across several pointer wraps.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        cyc(1'b1, 32'hC000_0000, 32'h100, 1'b0, 1'b0);
        cyc(1'b1, 32'hC000_0001, 32'h104, 1'b0, 1'b0);
        for (int i = 2; i < 2 + 3 * DEPTH; i++) begin
            cyc(1'b1, 32'hC000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b1, 1'b0);
            chk("stream_count", 64'(count), 64'd2);
        end
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Flush with push and pop offered: both dropped.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hD000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd3);
        cyc(1'b1, 32'hDEAD_BEEF, 32'h300, 1'b1, 1'b1);
        chk("flush_count3", 64'(count),     64'd0);
        chk("flush_valid",  64'(out_valid), 64'd0);
        cyc(1'b1, 32'h0000_0055, 32'h304, 1'b0, 1'b0);
        chk("post_flush_head", 64'(out_instr), 64'h55);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries held.
        cyc(1'b1, 32'hE000_0000, 32'h400, 1'b0, 1'b0);
        cyc(1'b1, 32'hE000_0001, 32'h404, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("pre_arst_count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count",     64'(count),     64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd1);
        chk("arst_out_instr", 64'(out_instr), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
                1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 3));
        end
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
